// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction fetch slice.
package mips_pkg;

  localparam int          WORD_W   = 32;
  localparam logic [31:0] INST_NOP = 32'h0000_0000;
  localparam logic [31:0] PC_INCR  = 32'd4;

  typedef enum logic [1:0] {
    IF_IDLE,
    IF_RUN,
    IF_HALT
  } if_state_t;

endpackage

// File: rtl/instruction_fetch_unit_if_id_stage_reg.sv
// IF/ID output register: flush clears valid, load captures a new entry,
// otherwise the entry (and its valid flag) holds.
module if_id_stage_reg
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_flush,
  input  logic [WORD_W-1:0] i_inst,
  input  logic [WORD_W-1:0] i_pc,
  input  logic [WORD_W-1:0] i_pc_plus4,
  output logic              o_valid,
  output logic [WORD_W-1:0] o_inst,
  output logic [WORD_W-1:0] o_pc,
  output logic [WORD_W-1:0] o_pc_plus4
);

  logic              r_valid;
  logic [WORD_W-1:0] r_inst;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_pc_plus4;

  // Flush outranks load; contents are kept on flush, only valid drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_inst     <= INST_NOP;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid    <= 1'b1;
      r_inst     <= i_inst;
      r_pc       <= i_pc;
      r_pc_plus4 <= i_pc_plus4;
    end
  end

  assign o_valid    = r_valid;
  assign o_inst     = r_inst;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC, IDLE/RUN/HALT control, range and alignment
// checks, feeding the IF/ID register toward decode.
// Optional macro IF_PERF_COUNT_EN adds fetch/stall/flush counters.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_inst,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [WORD_W-1:0] if_inst,
  output logic [WORD_W-1:0] if_pc,
  output logic [WORD_W-1:0] if_pc_plus4,
  output logic              halted,
  output logic              fetch_fault
`ifdef IF_PERF_COUNT_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count,
  output logic [15:0]       flush_count
`endif
);

  logic [WORD_W-1:0] r_pc;
  if_state_t         r_state;
  logic              r_halted;
  logic              r_fault;

  logic              w_if_valid;
  logic              w_adv;
  logic              w_in_range;
  logic              w_redirect;
  logic              w_misaligned;
  logic              w_run_adv;
  logic              w_load;
  logic              w_flush;
  logic [WORD_W-1:0] w_pc_plus4;

  assign imem_addr    = {2'b00, r_pc[31:2]};
  assign w_pc_plus4   = r_pc + PC_INCR;
  assign w_adv        = !w_if_valid || id_ready;
  assign w_in_range   = imem_addr < 32'(IMEM_DEPTH);
  assign w_redirect   = redirect_valid && (r_state != IF_IDLE);
  assign w_misaligned = redirect_pc[1:0] != 2'b00;
  assign w_run_adv    = (r_state == IF_RUN) && w_adv && !w_redirect;
  assign w_load       = w_run_adv && w_in_range;
  // Running off the end only happens on an advance, so the current entry
  // is either empty or being consumed this cycle and can be dropped.
  assign w_flush      = w_redirect || (w_run_adv && !w_in_range) ||
                        ((r_state == IF_HALT) && id_ready);

  // PC and state machine; redirect has priority over sequential fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_state  <= IF_IDLE;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else if (r_state == IF_IDLE) begin
      r_state <= IF_RUN;
    end else if (w_redirect) begin
      r_pc <= redirect_pc;
      if (w_misaligned) begin
        r_state  <= IF_HALT;
        r_halted <= 1'b1;
        r_fault  <= 1'b1;
      end else begin
        r_state  <= IF_RUN;
        r_halted <= 1'b0;
      end
    end else if (w_run_adv) begin
      if (w_in_range) begin
        r_pc <= w_pc_plus4;
      end else begin
        r_state  <= IF_HALT;
        r_halted <= 1'b1;
      end
    end
  end

  assign halted      = r_halted;
  assign fetch_fault = r_fault;

  if_id_stage_reg u_stage (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_flush    (w_flush),
    .i_inst     (imem_inst),
    .i_pc       (r_pc),
    .i_pc_plus4 (w_pc_plus4),
    .o_valid    (w_if_valid),
    .o_inst     (if_inst),
    .o_pc       (if_pc),
    .o_pc_plus4 (if_pc_plus4)
  );

  assign if_valid = w_if_valid;

`ifdef IF_PERF_COUNT_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;
  logic [15:0] r_flush_count;

  // Event counters; all wrap naturally on overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_load) r_fetch_count <= r_fetch_count + 32'd1;
      if ((r_state == IF_RUN) && w_if_valid && !id_ready)
        r_stall_count <= r_stall_count + 32'd1;
      if (w_redirect && w_if_valid) r_flush_count <= r_flush_count + 16'd1;
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;
`endif

endmodule
